writeback_queue: RTL
====================

# writeback_queue

Buffers register-writeback requests from the execute/memory stages and issues them one per cycle to the register bank write port. Its `destination` output drives `Decoder4to16.in` directly, and `write_en` qualifies the decoder's one-hot output into per-register write strobes. A DEPTH-entry in-order FIFO absorbs bursts while the bank is stalled. A 16-bit busy vector flags registers with pending writes so issue logic can detect read-after-write hazards.

## Interface
- `DATA_WIDTH`, 32, width of a register write value
- `DEPTH`, 4, queue entries; power of two, ≥2
- `CNT_WIDTH`, 3, width of `count`; must equal log2(DEPTH)+1

- `clk`  in  1  single clock; all state updates on rising edge
- `reset_n`  in  1  synchronous active-low reset, sampled on `clk` rising edge
- `flush`  in  1  synchronous discard of all queued entries
- `wb_valid`  in  1  producer presents a writeback request
- `wb_ready`  out  1  queue can accept; equals !full
- `wb_dest`  in  4  destination register index 0..15
- `wb_data`  in  DATA_WIDTH  value to write
- `stall`  in  1  register bank cannot take a write this cycle
- `destination`  out  4  head entry register index; feeds Decoder4to16 `in`
- `write_data`  out  DATA_WIDTH  head entry data
- `write_en`  out  1  bank write strobe this cycle
- `busy`  out  16  bit i = 1 iff an occupied entry targets register i
- `count`  out  CNT_WIDTH  number of occupied entries, 0..DEPTH

## Operation
- Storage: circular buffer of {dest, data}, with write pointer, read pointer and occupancy count. Pointers wrap modulo DEPTH.
- Push: occurs when `wb_valid && wb_ready`. `wb_dest` and `wb_data` are sampled only on accepted edges. `wb_valid` while full is ignored, with no push and no error. The producer holds its request until accepted.
- `wb_ready` = (count != DEPTH). It does not account for a same-cycle pop; when full, a push is refused even if a pop occurs on the same edge.
- Issue: `write_en` = (count != 0) && !stall && !flush. This is combinational from registered state plus `stall`/`flush`. A pop occurs on every edge where `write_en` is 1.
- `destination` and `write_data` show the head entry when count != 0, and are 0 when empty.
- Push and pop on the same edge: both take effect and count is unchanged. This includes the count=1 case, where the popped entry is the old head and the new entry becomes the head.
- Ordering: strictly in-order. Duplicate destinations are allowed; the later write lands last and therefore wins.
- `busy`: OR over occupied entries of the one-hot decode of dest. Recomputed from state, so a bit clears on the edge that pops the last entry for that register. A same-edge push to the same register keeps the bit set.
- Flush: on an edge with `flush`=1, pointers and count go to 0 and any simultaneous push is discarded. `write_en` is 0 during the flush cycle.
- Priority: reset_n=0, then flush, then push/pop.

## Timing
- Reset (`reset_n`=0 at an edge): count=0, pointers=0. Outputs after that edge: `write_en`=0, `destination`=0, `write_data`=0, `busy`=16'h0000, `count`=0, `wb_ready`=1.
- Reset mid-operation discards all entries with no write issued.
- Latency: a request accepted at edge N appears on `destination`/`write_data` in cycle N+1. With stall=0 and an empty queue, `write_en`=1 in cycle N+1 and the pop occurs at edge N+1. There is no same-cycle bypass.
- Throughput: 1 write per cycle sustained with simultaneous push and pop.
- `stall` asserted holds the head and outputs stable. The queue keeps accepting until full.
- `count` and `busy` update on the edge only; they do not change combinationally with `stall`.

## Test plan
- Reset: assert reset_n=0 for 2 cycles with wb_valid=1 -> after release, count=0, write_en=0, busy=0, wb_ready=1, and no entry queued.
- Single write: push dest=4'h5, data=32'hDEADBEEF, stall=0 -> next cycle destination=5, write_data=DEADBEEF, write_en=1, busy=16'h0020. The cycle after: write_en=0, busy=0, count=0.
- Fill and stall: stall=1, push dests 1,2,3,4 on consecutive cycles -> count=4, wb_ready=0, busy=16'h001E. A 5th push (dest 9) is refused. Release stall -> writes issue in order 1,2,3,4 on 4 consecutive cycles, then write_en=0.
- Sustained stream: push dest 0..15 each cycle with stall=0 -> each destination appears exactly once, one cycle after its push. count stays 1 throughout, except 0 before the first push and after the last pop.
- Duplicate dest: stall=1, push (7,32'h1) then (7,32'h2) -> busy[7]=1, count=2. Unstall -> writes issue with data 1 then data 2; busy[7] stays 1 until the second pop, then clears.
- Flush: with 3 entries queued and wb_valid=1, assert flush for one cycle -> write_en=0 that cycle, then count=0 and busy=0, and the concurrent push is dropped. A new push afterwards issues normally.

Source files
------------

// File: rtl/writeback_queue.sv
// writeback_queue: in-order FIFO of register writeback requests.
// The head entry is offered to the register bank write port every cycle the
// bank is not stalled; a 16-bit busy vector flags registers that still have a
// pending write so issue logic can detect read-after-write hazards.
module writeback_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [3:0]            wb_dest,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  stall,
  output logic [3:0]            destination,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  write_en,
  output logic [15:0]           busy,
  output logic [CNT_WIDTH-1:0]  count
);

  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [3:0]            dest_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [CNT_WIDTH-1:0]  count_q;
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_WIDTH'(DEPTH));
  // Readiness deliberately ignores a same-cycle pop: a full queue refuses.
  assign wb_ready = !full;
  assign write_en = !empty && !stall && !flush;
  assign pop      = write_en;
  // A flush discards any request presented in the same cycle.
  assign push     = wb_valid && !full && !flush;
  assign count    = count_q;

  assign destination = empty ? 4'h0 : dest_mem[rd_ptr];
  assign write_data  = empty ? '0   : data_mem[rd_ptr];

  // Control state: pointers and occupancy; reset beats flush beats push/pop.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_WIDTH'(1);
        2'b01:   count_q <= count_q - CNT_WIDTH'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage: written only on accepted requests.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; its contents are only ever read
    // through occupied slots, so stale values are never observed.
    if (reset_n && push) begin
      dest_mem[wr_ptr] <= wb_dest;
      data_mem[wr_ptr] <= wb_data;
    end
  end

  // Busy vector: OR of the one-hot destination of every occupied entry.
  always_comb begin
    // NOTE: the default assignment before the loop keeps this purely
    // combinational; without it unassigned bits would infer latches.
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_WIDTH'(i) < count_q) begin
        busy[dest_mem[rd_ptr + PTR_WIDTH'(i)]] = 1'b1;
      end
    end
  end

endmodule
